demorgan_sweep: RTL

- Self-checking, parametrised De Morgan engine; the sequential successor to the 2-input combinational De Morgan truth-table check.
- On `start` it walks all 2^WIDTH input vectors, one per clock.
- For each vector it evaluates the NOR and NAND forms both ways: the reduction form and the inverted-inputs form.
- Each row is published on a registered output; mismatches are counted; pass/fail is reported at the end.
- Sits in the verification/self-test area; drives a display bench or on-chip BIST status.

---
 rtl/demorgan_sweep.sv | 130 +++++++++++++
 1 files changed

// File: rtl/demorgan_sweep.sv
// rtl/demorgan_sweep.sv - self-checking De Morgan sweep over all 2^WIDTH input vectors
// Stage register holds one row per clock; the check stage compares both identity forms.
module demorgan_sweep #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fault_inject,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             row_valid,
  output logic [WIDTH-1:0] row_vec,
  output logic [5:0]       row_bits,
  output logic [WIDTH:0]   mismatch_count,
  output logic [WIDTH-1:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             row_valid_q, row_valid_d;
  logic [WIDTH-1:0] row_vec_q, row_vec_d;
  logic [5:0]       row_bits_q, row_bits_d;
  logic [WIDTH:0]   mismatch_q, mismatch_d;
  logic [WIDTH-1:0] first_fail_q, first_fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mis;
  logic [5:0]       eval_bits;

  // row_bits layout: {and_r, or_r, nor_lhs, nor_rhs, nand_lhs, nand_rhs}
  always_comb begin
    eval_bits = {&vec_q, |vec_q, ~(|vec_q), &(~vec_q), ~(&vec_q), (|(~vec_q)) ^ fault_inject};
    mis       = row_valid_q & ((row_bits_q[3] != row_bits_q[2]) | (row_bits_q[1] != row_bits_q[0]));
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    row_valid_d  = row_valid_q;
    row_vec_d    = row_vec_q;
    row_bits_d   = row_bits_q;
    mismatch_d   = mismatch_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    done_d       = done_q;
    pass_d       = pass_q;

    // Checks the row published on the previous edge
    if (mis) begin
      mismatch_d = mismatch_q + 1'b1;
      if (!fail_seen_q) begin
        first_fail_d = row_vec_q;
        fail_seen_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          vec_d        = '0;
          row_valid_d  = 1'b0;
          mismatch_d   = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        row_valid_d = 1'b1;
        row_vec_d   = vec_q;
        row_bits_d  = eval_bits;
        if (vec_q == {WIDTH{1'b1}}) begin
          state_d = DRAIN;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      DRAIN: begin
        row_valid_d = 1'b0;
        state_d     = DONE;
        done_d      = 1'b1;
        pass_d      = (mismatch_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      row_valid_q  <= 1'b0;
      row_vec_q    <= '0;
      row_bits_q   <= '0;
      mismatch_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      row_valid_q  <= row_valid_d;
      row_vec_q    <= row_vec_d;
      row_bits_q   <= row_bits_d;
      mismatch_q   <= mismatch_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign row_valid      = row_valid_q;
  assign row_vec        = row_vec_q;
  assign row_bits       = row_bits_q;
  assign mismatch_count = mismatch_q;
  assign first_fail_vec = first_fail_q;

endmodule
